// File: rtl/flash_spi_engine.sv
// flash_spi_engine: DW-bit SPI master for the configuration flash.
// Shifts a word out on SO and in from SI with FCK = CLK/(2*HP), drives its own
// chip select (optionally held across words) and reports BUSY and overrun.
module flash_spi_engine #(
    parameter int DW        = 8,
    parameter int HP        = 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic          i_ws,
    input  logic          i_rs,
    input  logic          i_cs_hold,
    inout  wire  [DW-1:0] io_data,
    output logic          o_busy,
    output logic          o_ovr,
    input  logic          i_si,
    output logic          o_so,
    output logic          o_fck,
    output logic          o_fcs_n
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DESEL = 2'd3;

    // Edge counter spans the 2*DW-1 FCK edges that follow the entry falling edge.
    localparam int          EW        = $clog2(2 * DW);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);
    localparam logic [7:0]  DIV_LAST  = 8'(HP - 1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_osreg;
    logic [DW-1:0] r_isreg;
    logic          r_fck;
    logic          r_fcs_n;
    logic          r_busy;
    logic          r_ovr;
    logic          r_hold;
    logic [7:0]    r_div;
    logic [EW-1:0] r_edge;

    logic          w_ws_ok;
    logic          w_ovr_set;
    logic          w_div_done;
    logic          w_so;
    logic [DW-1:0] w_os_shift;
    logic [DW-1:0] w_is_shift;

    // A write is only taken when not colliding with a read and while we own the bus.
    assign w_ws_ok    = i_ws & ~i_rs & i_enable;
    // Any write strobe landing mid-transfer is an overrun, even one lost to a read collision.
    assign w_ovr_set  = i_ws & i_enable & r_busy;
    assign w_div_done = (r_div == DIV_LAST);

    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_so       = r_osreg[0];
            assign w_os_shift = {1'b0, r_osreg[DW-1:1]};
            assign w_is_shift = {i_si, r_isreg[DW-1:1]};
        end else begin : g_msb
            assign w_so       = r_osreg[DW-1];
            assign w_os_shift = {r_osreg[DW-2:0], 1'b0};
            assign w_is_shift = {r_isreg[DW-2:0], i_si};
        end
    endgenerate

    // Transfer sequencer: select, FCK generation, shifting, deselect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_osreg <= '0;
            r_isreg <= '0;
            r_fck   <= 1'b1;
            r_fcs_n <= 1'b1;
            r_busy  <= 1'b0;
            r_hold  <= 1'b0;
            r_div   <= '0;
            r_edge  <= '0;
        end else if (!i_enable) begin
            // Losing bus mastership aborts everything except the captured input bits.
            r_state <= S_IDLE;
            r_fck   <= 1'b1;
            r_fcs_n <= 1'b1;
            r_busy  <= 1'b0;
            r_hold  <= 1'b0;
            r_div   <= '0;
            r_edge  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ws_ok) begin
                        r_osreg <= io_data;
                        r_hold  <= i_cs_hold;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_edge  <= '0;
                        if (r_fcs_n) begin
                            r_state <= S_SETUP;
                            r_fcs_n <= 1'b0;
                        end else begin
                            // Select still held from the previous word: no setup phase.
                            r_state <= S_SHIFT;
                            r_fck   <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    if (w_div_done) begin
                        r_state <= S_SHIFT;
                        r_fck   <= 1'b0;
                        r_div   <= '0;
                        r_edge  <= '0;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        if (r_edge == LAST_EDGE) begin
                            // Final high phase done; FCK stays high from here on.
                            if (r_hold) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_DESEL;
                            end
                        end else begin
                            r_edge <= r_edge + 1'b1;
                            if (!r_fck) begin
                                r_fck   <= 1'b1;
                                r_isreg <= w_is_shift;
                            end else begin
                                r_fck   <= 1'b0;
                                r_osreg <= w_os_shift;
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    if (w_div_done) begin
                        r_state <= S_IDLE;
                        r_fcs_n <= 1'b1;
                        r_busy  <= 1'b0;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
            endcase
        end
    end

    // Sticky overrun flag; a coincident overrun beats the read-clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovr <= 1'b0;
        end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
        end else if (i_rs) begin
            r_ovr <= 1'b0;
        end
    end

    assign o_busy  = r_busy;
    assign o_ovr   = r_ovr;
    assign io_data = i_rs ? r_isreg : {DW{1'bz}};
    assign o_so    = i_enable ? w_so : 1'bz;
    assign o_fck   = i_enable ? r_fck : 1'bz;
    assign o_fcs_n = i_enable ? r_fcs_n : 1'bz;

endmodule

// File: tb/tb_flash_spi_engine.sv
// tb_flash_spi_engine: scoreboard bench for flash_spi_engine (HP=1 and HP=3 instances).
module tb_flash_spi_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // HP=1 instance
    logic       rst, en, ws, rs, cs_hold, si, si_val, si_loop;
    logic [7:0] drv_val;
    logic       drv_en;
    wire  [7:0] data_bus;
    logic       busy, ovr;
    wire        so, fck, fcs_n;

    assign data_bus = drv_en ? drv_val : 8'bz;
    assign si       = si_loop ? so : si_val;
    // Released lines settle opposite to the value they carry mid-transfer.
    pulldown pd_so  (so);
    pulldown pd_fck (fck);
    pullup   pu_fcs (fcs_n);

    flash_spi_engine #(.DW(8), .HP(1), .LSB_FIRST(1'b0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_ws(ws), .i_rs(rs),
        .i_cs_hold(cs_hold), .io_data(data_bus), .o_busy(busy), .o_ovr(ovr),
        .i_si(si), .o_so(so), .o_fck(fck), .o_fcs_n(fcs_n)
    );

    // HP=3 instance
    logic       ws3, rs3, si3, drv3_en;
    logic [7:0] drv3_val;
    wire  [7:0] data3;
    logic       busy3, ovr3, so3, fck3, fcs3_n;

    assign data3 = drv3_en ? drv3_val : 8'bz;

    flash_spi_engine #(.DW(8), .HP(3), .LSB_FIRST(1'b0)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_ws(ws3), .i_rs(rs3),
        .i_cs_hold(1'b0), .io_data(data3), .o_busy(busy3), .o_ovr(ovr3),
        .i_si(si3), .o_so(so3), .o_fck(fck3), .o_fcs_n(fcs3_n)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_expected(output logic [7:0] e);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got 0 entries expected at least 1");
            e = 8'h00;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    // Read ISREG combinationally, without letting a clock edge see RS.
    task automatic peek_read(input string tag);
        logic [7:0] e;
        rs = 1'b1;
        #1;
        pop_expected(e);
        check_value(tag, {24'h0, data_bus}, {24'h0, e});
        rs = 1'b0;
    endtask

    // Full read cycle: RS is sampled by one clock edge.
    task automatic read_word(input string tag);
        logic [7:0] e;
        rs = 1'b1;
        #1;
        pop_expected(e);
        check_value(tag, {24'h0, data_bus}, {24'h0, e});
        step();
        rs = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d, input logic hold);
        drv_val = d;
        drv_en  = 1'b1;
        cs_hold = hold;
        ws      = 1'b1;
        step();
        ws      = 1'b0;
        drv_en  = 1'b0;
        cs_hold = 1'b0;
    endtask

    // Follow one word until BUSY drops; optionally inject a stray WS at sample ws_at.
    task automatic run_word(input int ws_at, input logic [7:0] ws_data,
                            output int busy_cyc, output int rises,
                            output logic [7:0] so_bits, output logic fcs_hi_seen);
        logic prev_fck;
        int   c;
        busy_cyc    = 0;
        rises       = 0;
        so_bits     = 8'h00;
        fcs_hi_seen = 1'b0;
        prev_fck    = fck;
        c           = 0;
        while (busy && c < 200) begin
            busy_cyc++;
            if (fcs_n) fcs_hi_seen = 1'b1;
            if (fck && !prev_fck) begin
                rises++;
                so_bits = {so_bits[6:0], so};
            end
            prev_fck = fck;
            if (c == ws_at) begin
                drv_val = ws_data;
                drv_en  = 1'b1;
                ws      = 1'b1;
            end else if (ws) begin
                ws     = 1'b0;
                drv_en = 1'b0;
            end
            step();
            c++;
        end
        ws     = 1'b0;
        drv_en = 1'b0;
        if (c >= 200) check_value("busy_timeout", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc, r, rises, low_len, high_len, bad_low, bad_high, c;
        logic [7:0] sob, p3, e3;
        logic       fh, fh_all, prev, seen;

        rst = 1'b1; en = 1'b1; ws = 1'b0; rs = 1'b0; cs_hold = 1'b0;
        si_val = 1'b0; si_loop = 1'b1; drv_val = 8'h00; drv_en = 1'b0;
        ws3 = 1'b0; rs3 = 1'b0; si3 = 1'b0; drv3_en = 1'b0; drv3_val = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check_value("rst_fck", {31'h0, fck}, 32'h1);
        check_value("rst_fcs_n", {31'h0, fcs_n}, 32'h1);
        check_value("rst_busy", {31'h0, busy}, 32'h0);
        check_value("rst_ovr", {31'h0, ovr}, 32'h0);
        check_value("rst_busy3", {31'h0, busy3}, 32'h0);
        sb_q.push_back(8'h00);
        read_word("rst_isreg");

        // Single word, fresh select, SI looped to SO
        sb_q.push_back(8'hA5);
        write_word(8'hA5, 1'b0);
        check_value("t1_fcs_fall", {31'h0, fcs_n}, 32'h0);
        run_word(-1, 8'h00, bc, r, sob, fh);
        check_value("t1_busy_cycles", bc, 18);
        check_value("t1_fck_pulses", r, 8);
        check_value("t1_so_pattern", {24'h0, sob}, 32'hA5);
        check_value("t1_fcs_end", {31'h0, fcs_n}, 32'h1);
        read_word("t1_read");

        // Held chip select chain, SI tied high
        si_loop = 1'b0;
        si_val  = 1'b1;
        write_word(8'h9F, 1'b1);
        run_word(-1, 8'h00, bc, r, sob, fh);
        fh_all = fh;
        check_value("t2_w1_busy", bc, 17);
        check_value("t2_w1_so", {24'h0, sob}, 32'h9F);
        check_value("t2_gap1_fcs", {31'h0, fcs_n}, 32'h0);
        write_word(8'h00, 1'b1);
        run_word(-1, 8'h00, bc, r, sob, fh);
        fh_all = fh_all | fh;
        check_value("t2_w2_busy", bc, 16);
        check_value("t2_gap2_fcs", {31'h0, fcs_n}, 32'h0);
        sb_q.push_back(8'hFF);
        write_word(8'h00, 1'b0);
        run_word(-1, 8'h00, bc, r, sob, fh);
        fh_all = fh_all | fh;
        check_value("t2_w3_busy", bc, 17);
        check_value("t2_fcs_continuous", {31'h0, fh_all}, 32'h0);
        check_value("t2_fcs_end", {31'h0, fcs_n}, 32'h1);
        read_word("t2_read");

        // HP=3: phase widths and SI glitch in mid low phase
        p3 = 8'h6B;
        sb_q.push_back(p3);
        drv3_val = 8'h3C;
        drv3_en  = 1'b1;
        ws3      = 1'b1;
        step();
        ws3 = 1'b0;
        drv3_en = 1'b0;
        bc = 0; rises = 0; low_len = 0; high_len = 0; bad_low = 0; bad_high = 0;
        seen = 1'b0; prev = fck3; c = 0;
        while (busy3 && c < 400) begin
            bc++;
            if (fck3 && !prev) begin
                rises++;
                if (low_len != 3) bad_low++;
                low_len  = 0;
                high_len = 1;
                seen     = 1'b1;
            end else if (fck3) begin
                high_len++;
            end else begin
                if (prev && seen && high_len != 3) bad_high++;
                low_len++;
                if (low_len == 1 && rises < 8) si3 = ~p3[7-rises];
                if (low_len == 3 && rises < 8) si3 = p3[7-rises];
            end
            prev = fck3;
            step();
            c++;
        end
        if (c >= 400) check_value("t3_timeout", {31'h0, busy3}, 32'h0);
        check_value("t3_busy_cycles", bc, 54);
        check_value("t3_rises", rises, 8);
        check_value("t3_bad_low", bad_low, 0);
        check_value("t3_bad_high", bad_high, 0);
        rs3 = 1'b1;
        #1;
        pop_expected(e3);
        check_value("t3_read", {24'h0, data3}, {24'h0, e3});
        rs3 = 1'b0;
        step();

        // Overrun: stray WS during a transfer
        si_loop = 1'b1;
        sb_q.push_back(8'h5A);
        write_word(8'h5A, 1'b0);
        run_word(4, 8'hFF, bc, r, sob, fh);
        check_value("t4_busy_cycles", bc, 18);
        check_value("t4_so_unchanged", {24'h0, sob}, 32'h5A);
        check_value("t4_ovr_set", {31'h0, ovr}, 32'h1);
        read_word("t4_read");
        check_value("t4_ovr_clear", {31'h0, ovr}, 32'h0);

        // WS and RS together while idle: read serviced, write dropped
        sb_q.push_back(8'h5A);
        ws = 1'b1;
        read_word("conflict_read");
        ws = 1'b0;
        check_value("conflict_busy", {31'h0, busy}, 32'h0);
        check_value("conflict_ovr", {31'h0, ovr}, 32'h0);

        // ENABLE dropped after three rising edges; ISREG keeps old bits shifted by 3
        sb_q.push_back((8'h5A << 3) | 8'h05);
        write_word(8'hA5, 1'b0);
        rises = 0; prev = fck; c = 0;
        while (rises < 3 && c < 100) begin
            step();
            if (fck && !prev) rises++;
            prev = fck;
            c++;
        end
        check_value("t5_reached_3_rises", rises, 3);
        en = 1'b0;
        #1;
        check_value("t5_fck_released", {31'h0, fck}, 32'h0);
        check_value("t5_so_released", {31'h0, so}, 32'h0);
        check_value("t5_fcs_released", {31'h0, fcs_n}, 32'h1);
        step();
        drv_val = 8'h33; drv_en = 1'b1; ws = 1'b1;
        step();
        ws = 1'b0; drv_en = 1'b0;
        check_value("t5_ws_disabled_busy", {31'h0, busy}, 32'h0);
        check_value("t5_ws_disabled_ovr", {31'h0, ovr}, 32'h0);
        en = 1'b1;
        #1;
        check_value("t5_fck_idle", {31'h0, fck}, 32'h1);
        check_value("t5_fcs_idle", {31'h0, fcs_n}, 32'h1);
        read_word("t5_read_partial");

        // Asynchronous reset between clock edges mid-shift
        write_word(8'hA5, 1'b0);
        repeat (6) step();
        check_value("t6_busy_before", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_fck", {31'h0, fck}, 32'h1);
        check_value("t6_fcs_n", {31'h0, fcs_n}, 32'h1);
        check_value("t6_busy", {31'h0, busy}, 32'h0);
        sb_q.push_back(8'h00);
        peek_read("t6_isreg");
        #1;
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
